uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_baud_tick.sv | 39 +++
 rtl/uart_tx.sv | 125 ++++++++++++
 tb/tb_uart_tx.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter and the existing receiver.
// PARITY exists in the state enum only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned DATA_BITS   = 8;
  localparam int unsigned BIT_IDX_W   = $clog2(DATA_BITS);
  localparam logic        START_LEVEL = 1'b0;
  localparam logic        STOP_LEVEL  = 1'b1;
  localparam logic        IDLE_LEVEL  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } uart_state_e;

  // Even parity: the XOR of all data bits.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: a one-cycle tick every CLKS_PER_BIT clocks.
// restart realigns the period so the first tick closes a full bit.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned      CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tick_q;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  // tick is computed from the next count so it is high exactly while cnt_q == LAST
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= (LAST == '0);
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == LAST);
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_tx.sv
// Byte-wide UART transmitter: start, D7..D0 MSB first, stop; valid/ready intake.
// Define UART_TX_PARITY_EN to insert an even-parity bit before stop (11-bit frame).
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy
);

  uart_state_e          state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [BIT_IDX_W-1:0] bit_idx_q;
  logic                 tx_q;
  logic                 ready_q;
  logic                 busy_q;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q;
`endif

  logic accept;
  logic tick;

  assign accept = valid && ready_q;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .restart(accept),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= IDLE_LEVEL;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          tx_q    <= IDLE_LEVEL;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          if (accept) begin
            state_q   <= START;
            shift_q   <= data;
            bit_idx_q <= '0;
            tx_q      <= START_LEVEL;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= even_parity(data);
`endif
          end
        end
        START: begin
          if (tick) begin
            state_q <= DATA;
            tx_q    <= shift_q[DATA_BITS-1];
            shift_q <= {shift_q[DATA_BITS-2:0], 1'b0};
          end
        end
        // bit_idx_q counts data bits already on the line; index 7 is D0
        DATA: begin
          if (tick) begin
            if (bit_idx_q == BIT_IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              state_q <= PARITY;
              tx_q    <= parity_q;
`else
              state_q <= STOP;
              tx_q    <= STOP_LEVEL;
`endif
            end else begin
              tx_q      <= shift_q[DATA_BITS-1];
              shift_q   <= {shift_q[DATA_BITS-2:0], 1'b0};
              bit_idx_q <= bit_idx_q + BIT_IDX_W'(1);
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state_q <= STOP;
            tx_q    <= STOP_LEVEL;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            state_q <= IDLE;
            tx_q    <= IDLE_LEVEL;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= IDLE_LEVEL;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign tx    = tx_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx at CLKS_PER_BIT=1 (with a loopback receiver model) and 4.
// Honours UART_TX_PARITY_EN for frame length and parity expectations.
module tb_uart_tx;
  import uart_pkg::*;

`ifdef UART_TX_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame10;  // no-parity frame, first bit on the line in bit 9
    logic       par;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst1, valid1, ready1, tx1, busy1;
  logic       rst4, valid4, ready4, tx4, busy4;
  logic [7:0] data1, data4;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst1), .data(data1), .valid(valid1),
    .ready(ready1), .tx(tx1), .busy(busy1)
  );

  uart_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst4), .data(data4), .valid(valid4),
    .ready(ready4), .tx(tx4), .busy(busy4)
  );

  int         checks = 0;
  int         errors = 0;
  int         n_sent = 0;
  int         rx_frames = 0;
  logic [7:0] sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] exp_frame(input vec_t v);
`ifdef UART_TX_PARITY_EN
    return {v.frame10[9:1], v.par, v.frame10[0]};
`else
    return {1'b0, v.frame10};
`endif
  endfunction

  // Receiver model on dut1's line: shifts left, inserts at bit 0, checks the scoreboard.
  int         rx_cnt = 0;
  logic       rx_act = 1'b0;
  logic [7:0] rx_sh = 8'h00;
  always @(negedge clk) begin
    if (rst1) begin
      rx_act = 1'b0;
      rx_cnt = 0;
      rx_sh  = 8'h00;
    end else if (!rx_act) begin
      if (tx1 === START_LEVEL) begin
        rx_act = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt <= 8) begin
        rx_sh = {rx_sh[6:0], tx1};
`ifdef UART_TX_PARITY_EN
      end else if (rx_cnt == 9) begin
        if (sb_q.size() > 0) check("rx_parity", tx1, ^sb_q[0]);
`endif
      end else if (rx_cnt == FRAME_BITS - 1) begin
        rx_act = 1'b0;
        rx_frames++;
        check("rx_stop", tx1, STOP_LEVEL);
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected_frame: got %02h expected no frame", rx_sh);
        end else begin
          check("rx_data", rx_sh, sb_q.pop_front());
        end
      end
    end
  end

  task automatic send1(input logic [7:0] d);
    int n;
    n = 0;
    while (ready1 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready1_wait", ready1, 1'b1);
    data1  = d;
    valid1 = 1'b1;
    sb_q.push_back(d);
    n_sent++;
    @(negedge clk);
    valid1 = 1'b0;
    data1  = ~d;  // must not disturb the frame in flight
  endtask

  task automatic capture1(output logic [10:0] bits);
    bits = '0;
    for (int b = 0; b < int'(FRAME_BITS); b++) begin
      bits = {bits[9:0], tx1};
      @(negedge clk);
    end
  endtask

  task automatic send4(input logic [7:0] d);
    int n;
    n = 0;
    while (ready4 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready4_wait", ready4, 1'b1);
    data4  = d;
    valid4 = 1'b1;
    @(negedge clk);
    valid4 = 1'b0;
    data4  = ~d;
  endtask

  vec_t        vecs[7];
  logic [10:0] obs;
  int          n, busy_n, low_run, high_run, glitch, bad;
  logic        phase_hi;

  initial begin
    vecs[0] = '{8'hA5, 10'b0101001011, 1'b0};
    vecs[1] = '{8'hE0, 10'b0111000001, 1'b1};
    vecs[2] = '{8'h00, 10'b0000000001, 1'b0};
    vecs[3] = '{8'hFF, 10'b0111111111, 1'b0};
    vecs[4] = '{8'h3C, 10'b0001111001, 1'b0};
    vecs[5] = '{8'h81, 10'b0100000011, 1'b0};
    vecs[6] = '{8'h07, 10'b0000001111, 1'b1};

    rst1 = 1'b1; rst4 = 1'b1; valid1 = 1'b0; valid4 = 1'b0;
    data1 = 8'h00; data4 = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx1", tx1, IDLE_LEVEL);
    check("rst_ready1", ready1, 1'b0);
    check("rst_busy1", busy1, 1'b0);
    check("rst_tx4", tx4, IDLE_LEVEL);
    check("rst_ready4", ready4, 1'b0);
    check("rst_busy4", busy4, 1'b0);
    rst1 = 1'b0; rst4 = 1'b0;
    @(negedge clk);
    check("ready1_after_rst", ready1, 1'b1);
    check("ready4_after_rst", ready4, 1'b1);

    // table: exact line pattern per byte, then idle-high with ready
    for (int i = 0; i < 7; i++) begin
      send1(vecs[i].data);
      capture1(obs);
      check($sformatf("frame[%0d]", i), obs, exp_frame(vecs[i]));
      check($sformatf("ready_end[%0d]", i), ready1, 1'b1);
      check($sformatf("tx_idle[%0d]", i), tx1, IDLE_LEVEL);
    end

    // valid held high: next acceptance exactly one idle cycle after the frame
    n = 0;
    while (ready1 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    data1 = 8'h3C; valid1 = 1'b1;
    sb_q.push_back(8'h3C); n_sent++;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      data1 = 8'hC3;
    end while (ready1 !== 1'b1 && n < 100);
    check("b2b_period", n, FRAME_BITS + 1);
    sb_q.push_back(8'hC3); n_sent++;
    @(negedge clk);
    valid1 = 1'b0;
    check("b2b_start", tx1, START_LEVEL);
    repeat (FRAME_BITS + 2) @(negedge clk);

    // 0xFF offered on the third cycle of a 0x00 frame is dropped
    send1(8'h00);
    obs = '0;
    for (int b = 0; b < int'(FRAME_BITS); b++) begin
      obs = {obs[9:0], tx1};
      if (b == 2) begin
        check("ready_while_busy", ready1, 1'b0);
        valid1 = 1'b1;
        data1  = 8'hFF;
      end else begin
        valid1 = 1'b0;
      end
      @(negedge clk);
    end
    valid1 = 1'b0;
    check("ignored_valid_frame", obs, exp_frame(vecs[2]));
    repeat (3) @(negedge clk);
    check("no_queued_busy", busy1, 1'b0);
    check("no_queued_tx", tx1, IDLE_LEVEL);

    // CLKS_PER_BIT=4, 0x01: 32 low cycles then all high until busy drops
    send4(8'h01);
    busy_n = 0; low_run = 0; high_run = 0; glitch = 0; phase_hi = 1'b0;
    while (busy4 === 1'b1 && busy_n < 200) begin
      if (tx4 === 1'b0 && !phase_hi) low_run++;
      else if (tx4 === 1'b1) begin
        phase_hi = 1'b1;
        high_run++;
      end else glitch++;
      busy_n++;
      @(negedge clk);
    end
    check("cpb4_busy_cycles", busy_n, 4 * FRAME_BITS);
    check("cpb4_low_cycles", low_run, 32);
    check("cpb4_high_cycles", high_run, 4 * (FRAME_BITS - 8));
    check("cpb4_glitches", glitch, 0);
    check("cpb4_ready_end", ready4, 1'b1);
    check("cpb4_tx_end", tx4, IDLE_LEVEL);

    // reset in the middle of the data bits of 0x55 aborts the frame
    send4(8'h55);
    repeat (12) @(negedge clk);
    check("mid_frame_busy", busy4, 1'b1);
    rst4 = 1'b1;
    @(negedge clk);
    check("abort_tx", tx4, IDLE_LEVEL);
    check("abort_ready", ready4, 1'b0);
    check("abort_busy", busy4, 1'b0);
    rst4 = 1'b0;
    @(negedge clk);
    check("abort_ready_after", ready4, 1'b1);
    check("abort_tx_after", tx4, IDLE_LEVEL);
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      if (tx4 !== 1'b1 || busy4 !== 1'b0) bad++;
      @(negedge clk);
    end
    check("abort_no_resume", bad, 0);

    check("sb_drained", sb_q.size(), 0);
    check("rx_frame_count", rx_frames, n_sent);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
